// File: rtl/xalu_issue_ctrl.sv
// Issue controller for the HI/LO multiply-divide unit (E stage).
// Ports: clk/reset; req_valid/op/flush in, req_ready/stall out;
//   xalu_op/hi_we/lo_we/xalu_out_sel/rd_valid to the unit;
//   xalu_busy from the unit; busy_err sticky flag; stall_cnt.
module xalu_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic        req_flush,
  output logic        req_ready,
  output logic        stall,
  output logic [3:0]  xalu_op,
  output logic        hi_we,
  output logic        lo_we,
  output logic        xalu_out_sel,
  output logic        rd_valid,
  input  logic        xalu_busy,
  output logic        busy_err,
  output logic [31:0] stall_cnt
);

  localparam int MAXL = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW   = (MAXL > 2) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;
  logic is_mf;
  logic xreq;
  logic accept;
  logic busy_bad;

  // Request decode
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    is_mf   = 1'b0;
    case (req_op)
      4'd1, 4'd2,
      4'd5, 4'd6,
      4'd7, 4'd8:   is_mul  = 1'b1;
      4'd3, 4'd4:   is_div  = 1'b1;
      4'd9:         is_mthi = 1'b1;
      4'd10:        is_mtlo = 1'b1;
      4'd11, 4'd12: is_mf   = 1'b1;
      default:      ;
    endcase
  end

  assign xreq = req_valid &&
    (is_mul || is_div || is_mthi || is_mtlo || is_mf);

  assign req_ready = (state == IDLE);
  assign accept    = xreq && req_ready && !req_flush;
  assign stall     = xreq && !req_ready && !req_flush;

  // State register and bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (busy_bad)
        busy_err <= 1'b1;
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_nx = RUN;
          cnt_nx   = MUL_LOAD;
        end else if (accept && is_div) begin
          state_nx = RUN;
          cnt_nx   = DIV_LOAD;
        end
      end
      RUN: begin
        // The unit cannot be cancelled, so flush never leaves RUN early.
        cnt_nx = cnt - CNT_ONE;
        if (cnt == CNT_ONE)
          state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs to the unit
  always_comb begin
    xalu_op      = 4'd0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    rd_valid     = 1'b0;
    xalu_out_sel = (req_op == 4'd12);
    if (accept) begin
      if (is_mul || is_div)
        xalu_op = req_op;
      hi_we    = is_mthi;
      lo_we    = is_mtlo;
      rd_valid = is_mf;
    end
  end

  // Our own latency count and the unit's BUSY must agree.
  assign busy_bad =
    ((state == IDLE) && (xalu_op == 4'd0) && xalu_busy) ||
    ((state == RUN) && !xalu_busy);

endmodule

// File: tb/tb_xalu_issue_ctrl.sv
// Testbench for xalu_issue_ctrl with a small latency model of the unit.
// Ports of the DUT are all driven/observed from here.
module tb_xalu_issue_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic        req_flush;
  logic        req_ready;
  logic        stall;
  logic [3:0]  xalu_op;
  logic        hi_we;
  logic        lo_we;
  logic        xalu_out_sel;
  logic        rd_valid;
  logic        xalu_busy;
  logic        busy_err;
  logic [31:0] stall_cnt;

  int n_chk;
  int n_pass;

  // 0: model, 1: force busy high, 2: force busy low
  int busy_mode;
  int ucnt;

  xalu_issue_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_flush    (req_flush),
    .req_ready    (req_ready),
    .stall        (stall),
    .xalu_op      (xalu_op),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .xalu_out_sel (xalu_out_sel),
    .rd_valid     (rd_valid),
    .xalu_busy    (xalu_busy),
    .busy_err     (busy_err),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: busy for LAT-1 cycles after it sees a nonzero op.
  always @(posedge clk) begin
    if (reset)
      ucnt <= 0;
    else if (ucnt > 0)
      ucnt <= ucnt - 1;
    else if (xalu_op == 4'd3 || xalu_op == 4'd4)
      ucnt <= DIV_LAT - 1;
    else if (xalu_op != 4'd0)
      ucnt <= MUL_LAT - 1;
  end

  always_comb begin
    case (busy_mode)
      1:       xalu_busy = 1'b1;
      2:       xalu_busy = 1'b0;
      default: xalu_busy = (ucnt != 0);
    endcase
  end

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic        f;
    logic [9:0]  exp;
    logic [31:0] scnt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(
    input logic v, input logic [3:0] op, input logic f,
    input logic rdy, input logic stl, input logic [3:0] xop,
    input logic hi, input logic lo, input logic sel,
    input logic rdv, input logic [31:0] sc);
    vec_t r;
    r.v    = v;
    r.op   = op;
    r.f    = f;
    r.exp  = {rdy, stl, xop, hi, lo, sel, rdv};
    r.scnt = sc;
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {req_ready, stall, xalu_op, hi_we, lo_we,
            xalu_out_sel, rd_valid};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic f);
    req_valid = v;
    req_op    = op;
    req_flush = f;
  endtask

  // Advance to the next cycle; inputs change 1 after the edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    busy_mode = 0;
    drive(1'b0, 4'd0, 1'b0);
    next();
    next();
    reset = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    busy_mode = 0;
    reset     = 1'b0;
    drive(1'b0, 4'd0, 1'b0);

    //        v  op  f   rdy stl xop hi lo sel rdv scnt
    tbl[0]  = mk(1, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 11, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 11, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 11, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    tbl[4]  = mk(1, 11, 0, 0, 1, 0, 0, 0, 0, 0, 3);
    tbl[5]  = mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 1, 4);
    tbl[6]  = mk(1, 9,  0, 1, 0, 0, 1, 0, 0, 0, 4);
    tbl[7]  = mk(1, 5,  0, 1, 0, 5, 0, 0, 0, 0, 4);
    tbl[8]  = mk(1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    tbl[9]  = mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 5);
    tbl[10] = mk(1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 5);
    tbl[11] = mk(1, 12, 0, 0, 1, 0, 0, 0, 1, 0, 6);
    tbl[12] = mk(0, 12, 0, 1, 0, 0, 0, 0, 1, 0, 7);
    tbl[13] = mk(1, 12, 0, 1, 0, 0, 0, 0, 1, 1, 7);
    tbl[14] = mk(1, 10, 0, 1, 0, 0, 0, 1, 0, 0, 7);
    tbl[15] = mk(1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 7);
    tbl[16] = mk(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 7);
    tbl[17] = mk(1, 15, 0, 1, 0, 0, 0, 0, 0, 0, 7);
    tbl[18] = mk(1, 9,  1, 1, 0, 0, 0, 0, 0, 0, 7);
    tbl[19] = mk(0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 7);

    do_reset();
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_scnt", stall_cnt, 32'd0);
    check("reset_err", 32'(busy_err), 32'd0);
    next();

    // Table: mult + mfhi wait, mthi, madd + flushed mtlo, none codes
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].f);
      @(negedge clk);
      check($sformatf("tbl%0d_outs", i), 32'(outs()),
            32'(tbl[i].exp));
      check($sformatf("tbl%0d_scnt", i), stall_cnt, tbl[i].scnt);
      check($sformatf("tbl%0d_err", i), 32'(busy_err), 32'd0);
      next();
    end

    // divu then a waiting div
    do_reset();
    drive(1'b1, 4'd4, 1'b0);
    @(negedge clk);
    check("div0_xop", 32'(xalu_op), 32'd4);
    next();
    drive(1'b1, 4'd3, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("div_c%0d_rdy", c), 32'(req_ready), 32'd0);
      next();
    end
    @(negedge clk);
    check("div10_rdy", 32'(req_ready), 32'd1);
    check("div10_xop", 32'(xalu_op), 32'd3);
    next();
    drive(1'b0, 4'd0, 1'b0);
    for (int c = 11; c <= 19; c++) begin
      @(negedge clk);
      check($sformatf("div_c%0d_rdy", c), 32'(req_ready), 32'd0);
      next();
    end
    @(negedge clk);
    check("div20_rdy", 32'(req_ready), 32'd1);
    check("div_scnt", stall_cnt, 32'd9);
    check("div_err", 32'(busy_err), 32'd0);
    next();

    // Reset in the middle of a divide
    do_reset();
    drive(1'b1, 4'd3, 1'b0);
    next();
    drive(1'b1, 4'd1, 1'b0);
    next();
    @(negedge clk);
    check("rst_mid_scnt", stall_cnt, 32'd1);
    next();
    drive(1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    next();
    reset = 1'b0;
    drive(1'b1, 4'd2, 1'b0);
    @(negedge clk);
    check("rst_after_rdy", 32'(req_ready), 32'd1);
    check("rst_after_scnt", stall_cnt, 32'd0);
    check("rst_after_err", 32'(busy_err), 32'd0);
    check("rst_after_xop", 32'(xalu_op), 32'd2);
    next();
    drive(1'b0, 4'd0, 1'b0);
    for (int c = 1; c < MUL_LAT; c++) next();
    @(negedge clk);
    check("rst_mul_done", 32'(req_ready), 32'd1);
    check("rst_mul_err", 32'(busy_err), 32'd0);
    next();

    // BUSY high while idle with no request
    do_reset();
    busy_mode = 1;
    @(negedge clk);
    check("berr_idle_pre", 32'(busy_err), 32'd0);
    next();
    busy_mode = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("berr_idle_stick%0d", c), 32'(busy_err), 32'd1);
      next();
    end

    // BUSY dropping during RUN
    do_reset();
    drive(1'b1, 4'd1, 1'b0);
    next();
    drive(1'b0, 4'd0, 1'b0);
    @(negedge clk);
    check("berr_run_c1", 32'(busy_err), 32'd0);
    next();
    busy_mode = 2;
    @(negedge clk);
    check("berr_run_c2", 32'(busy_err), 32'd0);
    next();
    busy_mode = 0;
    @(negedge clk);
    check("berr_run_c3", 32'(busy_err), 32'd1);
    next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xalu_issue_ctrl.md
Name: xalu_issue_ctrl

Overview:
Initiator side of the HI/LO multiply-divide unit interface, placed in the E stage.
- Accepts one mult/div/madd/msub/mthi/mtlo/mfhi/mflo request per cycle from the pipeline.
- Drives the unit's op code, HI/LO write enables and output select.
- Tracks the unit's fixed latency with its own counter and stalls the pipeline until the unit can take the request.
- Cross-checks its counter against the unit's BUSY and keeps a stall-cycle counter.

Parameters:
MUL_LAT, 5, cycles from issue of op 1,2,5-8 until HI/LO hold the result and the unit is idle (must be >=2)
DIV_LAT, 10, cycles from issue of op 3,4 until HI/LO hold the result and the unit is idle (must be >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  pipeline request present this cycle
req_op  in  4  request code: 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 madd; 6 maddu; 7 msub; 8 msubu; 9 mthi; 10 mtlo; 11 mfhi; 12 mflo; 13-15 none
req_flush  in  1  kills this cycle's request
req_ready  out  1  controller can accept a request this cycle
stall  out  1  hold the pipeline this cycle
xalu_op  out  4  op code to the unit (0 = idle)
hi_we  out  1  HI write enable to the unit
lo_we  out  1  LO write enable to the unit
xalu_out_sel  out  1  unit output select: 0 = HI, 1 = LO
rd_valid  out  1  mfhi/mflo accepted; unit output is valid this cycle
xalu_busy  in  1  BUSY from the unit
busy_err  out  1  sticky mismatch flag
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset (synchronous, active-high): state IDLE, cnt=0, busy_err=0, stall_cnt=0.
  - Reset wins over every other event, including mid-operation. The unit shares the same reset and returns idle with it.
- Definitions:
  - xreq = req_valid && req_op in 1..12.
  - accept = xreq && req_ready && !req_flush.
- req_ready = (state==IDLE). Combinational.
- stall = xreq && !req_ready && !req_flush. Combinational.
  - Codes 0 and 13-15 never stall and never drive outputs.
- Combinational outputs, all 0 unless accept:
  - xalu_op = req_op when accept && req_op in 1..8.
  - hi_we = accept && req_op==9.
  - lo_we = accept && req_op==10.
  - rd_valid = accept && req_op in {11,12}.
  - xalu_out_sel = (req_op==12), regardless of accept.
  - xalu_op is nonzero for exactly the accept cycle.
- FSM states:
  - IDLE: on accept of op 1,2,5-8, load cnt=MUL_LAT-1 and go to RUN. On accept of op 3,4, load cnt=DIV_LAT-1 and go to RUN. Ops 9-12 complete in the accept cycle and the state stays IDLE.
  - RUN: if cnt==1, go to IDLE; otherwise cnt<=cnt-1.
  - Result: a request issued in cycle 0 is ready again in cycle LAT. No accept happens while in RUN.
- Flush: suppresses only the current cycle's accept and stall. It never aborts RUN, because the unit cannot be cancelled.
- busy_err is set at the clock edge when either holds, and is cleared only by reset:
  - state==IDLE && xalu_op==0 && xalu_busy==1
  - state==RUN && xalu_busy==0
- stall_cnt: +1 on every cycle with stall=1; saturates at 0xFFFFFFFF.
- Simultaneous events:
  - Flush and stall in the same cycle: no stall and no count.
  - cnt reaching 1 while a request is waiting: the request is accepted in the next cycle (IDLE), not the same cycle.

Test Plan:
1. After reset, issue op 1 in cycle 0 -> xalu_op=1 in cycle 0 only, req_ready=0 in cycles 1-4 and 1 in cycle 5. Hold op 11 from cycle 1 -> stall=1 in cycles 1-4; in cycle 5 rd_valid=1, xalu_out_sel=0; stall_cnt=4; busy_err=0.
2. Issue op 4, then hold op 3 -> second divide accepted in cycle 10 with xalu_op=3; req_ready low in cycles 1-9 and again in cycles 11-19.
3. Op 9 in IDLE -> hi_we=1 for one cycle, lo_we=0, no state change. Op 10 during RUN stalls; assert req_flush in one stall cycle -> stall=0 and lo_we=0 in that cycle; stall_cnt excludes that cycle.
4. Issue op 3, assert reset in cycle 3 -> next cycle req_ready=1, stall_cnt=0, busy_err=0. A new op 2 is accepted immediately.
5. Force xalu_busy=1 in IDLE with no request -> busy_err=1 from the next cycle and it stays 1. Reset, issue op 1, force xalu_busy=0 in cycle 2 -> busy_err=1.
6. req_valid=1 with req_op=0, then 13 -> stall=0, xalu_op=0, hi_we=lo_we=rd_valid=0, stall_cnt unchanged.
